stopwatch_ctrl: RTL

//  Start/stop/clear controller for the DE1-SoC seconds-counter/hex-display datapath.

---
 rtl/stopwatch_ctrl_pkg.sv | 41 ++++
 rtl/stopwatch_ctrl_if.sv | 30 +++
 rtl/stopwatch_ctrl_tick_gen.sv | 34 +++
 rtl/stopwatch_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the M:SS stopwatch controller.
// Includes the FSM state encoding, the BCD digit limits and a single-digit BCD increment helper.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ONES_MAX   = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX   = 4'd5;
    localparam int         NUM_DIGITS     = 3;
    localparam int         NUM_BTNS       = 2;
    localparam int         BTN_START_STOP = 0;
    localparam int         BTN_CLEAR      = 1;

    typedef struct packed {
        logic [3:0] digit;
        logic       carry;
    } bcd_step_t;

    // Digit 1 is seconds-tens (0-5); digits 0 and 2 count 0-9.
    function automatic logic [3:0] digit_limit(input int idx);
        return (idx == 1) ? BCD_TENS_MAX : BCD_ONES_MAX;
    endfunction

    // Any value at or past the limit (including illegal codes) rolls to 0 and carries.
    function automatic bcd_step_t bcd_inc(input logic [3:0] digit, input logic [3:0] limit);
        bcd_step_t res;
        if (digit >= limit) begin
            res.digit = 4'd0;
            res.carry = 1'b1;
        end else begin
            res.digit = digit + 4'd1;
            res.carry = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display/status outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
    logic       start_stop;
    logic       clear;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic       running;
    logic       wrap;

    modport master (
        output start_stop,
        output clear,
        input  sec_ones,
        input  sec_tens,
        input  min_ones,
        input  running,
        input  wrap
    );

    modport slave (
        input  start_stop,
        input  clear,
        output sec_ones,
        output sec_tens,
        output min_ones,
        output running,
        output wrap
    );
endinterface

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Count-step divider: tick is high on the last cycle of each TICK_DIV-cycle period while running.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIV_W    = 26
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic run,
    input  logic hold_zero,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_div;

    // When neither running nor held at zero the count freezes, keeping the partial second.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (hold_zero) begin
            r_div <= '0;
        end else if (run) begin
            if (r_div == DIV_LAST) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign tick = run && (r_div == DIV_LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear controller: button synchronizers, IDLE/RUN/PAUSE FSM and M:SS BCD cascade.
// Digits and status flags are all registered; the 1 s step comes from tick_gen.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIV_W    = 26
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    stopwatch_ctrl_if.slave  sw
);

    logic [NUM_BTNS-1:0] w_btn;
    logic [NUM_BTNS-1:0] r_s1;
    logic [NUM_BTNS-1:0] r_s2;
    logic [NUM_BTNS-1:0] r_s3;
    logic [NUM_BTNS-1:0] r_arm;
    logic [NUM_BTNS-1:0] w_rise;
    logic                r_live;

    assign w_btn[BTN_START_STOP] = sw.start_stop;
    assign w_btn[BTN_CLEAR]      = sw.clear;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // A button only arms after a genuine low sample, so one held through reset never edges.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_s3  <= '0;
            r_arm <= '0;
        end else begin
            r_s1  <= w_btn;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            r_arm <= r_arm | ({NUM_BTNS{r_live}} & ~r_s1);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_edge
            assign w_rise[gi] = r_s2[gi] & ~r_s3[gi] & r_arm[gi];
        end
    endgenerate

    logic w_ss_edge;
    logic w_clr_edge;

    assign w_ss_edge  = w_rise[BTN_START_STOP];
    assign w_clr_edge = w_rise[BTN_CLEAR];

    state_t r_state;
    logic   r_running;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
        end else if (w_clr_edge) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
        end else if (w_ss_edge) begin
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    r_state   <= ST_RUN;
                    r_running <= 1'b1;
                end
                ST_RUN: begin
                    r_state   <= ST_PAUSE;
                    r_running <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    logic w_run;
    logic w_hold_zero;
    logic w_tick;

    assign w_run       = (r_state == ST_RUN);
    assign w_hold_zero = (r_state == ST_IDLE) || w_clr_edge;

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_tick_gen (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .run       (w_run),
        .hold_zero (w_hold_zero),
        .tick      (w_tick)
    );

    // Digit 0 = sec_ones, 1 = sec_tens, 2 = min_ones; carry ripples upward from the tick.
    logic [NUM_DIGITS:0] w_carry;

    assign w_carry[0] = w_tick;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] r_digit;
            bcd_step_t  w_step;

            assign w_step        = bcd_inc(r_digit, digit_limit(gi));
            assign w_carry[gi+1] = w_carry[gi] & w_step.carry;

            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset) begin
                    r_digit <= 4'd0;
                end else if (w_clr_edge) begin
                    r_digit <= 4'd0;
                end else if (w_carry[gi]) begin
                    r_digit <= w_step.digit;
                end
            end
        end
    endgenerate

    logic r_wrap;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= ~w_clr_edge & w_carry[NUM_DIGITS];
        end
    end

    assign sw.sec_ones = g_digit[0].r_digit;
    assign sw.sec_tens = g_digit[1].r_digit;
    assign sw.min_ones = g_digit[2].r_digit;
    assign sw.running  = r_running;
    assign sw.wrap     = r_wrap;

endmodule
